rf_scoreboard: RTL and testbench

Parametrised integer register file with NUM_RD combinational read ports, one write-back port, same-cycle write-back bypass and a per-register busy scoreboard. It sits in the decode stage of the pipelined core. It gates the decode→execute handshake by stalling issue on RAW and WAW hazards against in-flight writers. Pipeline flush clears all pending reservations.

---
 rtl/rf_scoreboard.sv | 115 +++++++++++
 tb/tb_rf_scoreboard.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// Decode-stage integer register file with write-back bypass and a busy
// scoreboard that holds issue on RAW/WAW hazards against in-flight writers.
module rf_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             iss_valid,
  output logic                             iss_ready,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     rs_addr,
  input  logic [NUM_RD-1:0]                rs_used,
  output logic [NUM_RD*DATA_WIDTH-1:0]     rs_data,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic                             rd_wen,
  input  logic                             wb_valid,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0]            wb_data,
  input  logic                             flush,
  output logic [(1<<ADDR_WIDTH)-1:0]       busy_vec,
  output logic [CNT_WIDTH-1:0]             stall_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;

  logic [NUM_RD-1:0]     w_src_haz;
  logic                  w_rd_nz;
  logic                  w_wb_nz;
  logic                  w_waw;
  logic                  w_ready;
  logic                  w_fire;
  logic                  w_stall;
  logic                  w_cnt_sat;
  logic [DEPTH-1:0]      w_busy_nxt;

  // Per-lane read mux (x0, then bypass, then array) and RAW hazard detect
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_nz;
    logic                  w_byp;

    assign w_addr = rs_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_nz   = (w_addr != '0);
    assign w_byp  = wb_valid && (wb_addr == w_addr);

    assign rs_data[g*DATA_WIDTH +: DATA_WIDTH] =
      !w_nz ? '0 : (w_byp ? wb_data : r_rf[w_addr]);

    // A same-cycle write-back to the source resolves the hazard via bypass
    assign w_src_haz[g] = rs_used[g] && w_nz && r_busy[w_addr] && !w_byp;
  end

  assign w_rd_nz = (rd_addr != '0);
  assign w_wb_nz = (wb_addr != '0);

  // WAW: a second writer may not issue until the outstanding one retires
  assign w_waw   = rd_wen && w_rd_nz && r_busy[rd_addr] &&
                   !(wb_valid && (wb_addr == rd_addr));

  assign w_ready   = !flush && !(|w_src_haz) && !w_waw;
  assign w_fire    = iss_valid && w_ready;
  assign w_stall   = iss_valid && !w_ready;
  assign w_cnt_sat = (r_stall_cnt == {CNT_WIDTH{1'b1}});

  // Next scoreboard state: flush wins, then write-back clear, then issue set
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (wb_valid) begin
        w_busy_nxt[wb_addr] = 1'b0;
      end
      if (w_fire && rd_wen) begin
        w_busy_nxt[rd_addr] = 1'b1;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Register array: synchronous clear, write-back commits data for any non-x0 index
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rf[i] <= '0;
      end
    end else if (wb_valid && w_wb_nz) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Scoreboard and saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_stall && !w_cnt_sat) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign iss_ready = w_ready;
  assign busy_vec  = r_busy;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: default-parameter table plus a
// NUM_RD=3 / CNT_WIDTH=2 instance for lane-mask and saturation cases.
module tb_rf_scoreboard;

  logic clk;
  logic rst;

  // Default instance
  logic        iss_valid;
  logic        iss_ready;
  logic [9:0]  rs_addr;
  logic [1:0]  rs_used;
  logic [63:0] rs_data;
  logic [4:0]  rd_addr;
  logic        rd_wen;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  // Three-lane, 2-bit counter instance
  logic        b_iss_valid;
  logic        b_iss_ready;
  logic [14:0] b_rs_addr;
  logic [2:0]  b_rs_used;
  logic [95:0] b_rs_data;
  logic [4:0]  b_rd_addr;
  logic        b_rd_wen;
  logic        b_wb_valid;
  logic [4:0]  b_wb_addr;
  logic [31:0] b_wb_data;
  logic        b_flush;
  logic [31:0] b_busy_vec;
  logic [1:0]  b_stall_cnt;

  int n_checks;
  int n_errors;

  rf_scoreboard u_dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .rs_addr   (rs_addr),
    .rs_used   (rs_used),
    .rs_data   (rs_data),
    .rd_addr   (rd_addr),
    .rd_wen    (rd_wen),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flush     (flush),
    .busy_vec  (busy_vec),
    .stall_cnt (stall_cnt)
  );

  rf_scoreboard #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .NUM_RD     (3),
    .CNT_WIDTH  (2)
  ) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (b_iss_valid),
    .iss_ready (b_iss_ready),
    .rs_addr   (b_rs_addr),
    .rs_used   (b_rs_used),
    .rs_data   (b_rs_data),
    .rd_addr   (b_rd_addr),
    .rd_wen    (b_rd_wen),
    .wb_valid  (b_wb_valid),
    .wb_addr   (b_wb_addr),
    .wb_data   (b_wb_data),
    .flush     (b_flush),
    .busy_vec  (b_busy_vec),
    .stall_cnt (b_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        iss_valid;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic        wen;
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        flush;
    logic        e_ready;
    logic [31:0] e_rs0;
    logic [31:0] e_rs1;
    logic [31:0] e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic v, input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] u,
    input logic [4:0] rd, input logic wen, input logic wbv, input logic [4:0] wba,
    input logic [31:0] wbd, input logic fl, input logic er, input logic [31:0] e0,
    input logic [31:0] e1, input logic [31:0] eb, input logic [15:0] ec);
    vec_t t;
    t.iss_valid = v;  t.rs0 = r0;  t.rs1 = r1;  t.used = u;
    t.rd = rd;  t.wen = wen;  t.wbv = wbv;  t.wba = wba;  t.wbd = wbd;
    t.flush = fl;  t.e_ready = er;  t.e_rs0 = e0;  t.e_rs1 = e1;
    t.e_busy = eb;  t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_main();
    iss_valid = 1'b0; rs_addr = '0; rs_used = '0; rd_addr = '0; rd_wen = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic idle_b();
    b_iss_valid = 1'b0; b_rs_addr = '0; b_rs_used = '0; b_rd_addr = '0; b_rd_wen = 1'b0;
    b_wb_valid = 1'b0; b_wb_addr = '0; b_wb_data = '0; b_flush = 1'b0;
  endtask

  logic [1:0] e_bcnt;

  initial begin
    n_checks = 0;
    n_errors = 0;

    //        v  rs0 rs1 used rd  wen wbv wba wbd            fl rdy rs0 exp        rs1 exp      busy          cnt
    vecs[0]  = mk(1, 0, 0, 2'b00, 5, 1, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,        32'h0,        16'd0);
    vecs[1]  = mk(1, 5, 0, 2'b01, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        32'h20,       16'd0);
    vecs[2]  = mk(1, 5, 0, 2'b01, 0, 0, 1, 5, 32'hDEADBEEF,  0, 1, 32'hDEADBEEF, 32'h0,        32'h20,       16'd1);
    vecs[3]  = mk(0, 5, 0, 2'b01, 0, 0, 0, 0, 32'h0,         0, 1, 32'hDEADBEEF, 32'h0,        32'h0,        16'd1);
    vecs[4]  = mk(1, 0, 0, 2'b11, 0, 1, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,        32'h0,        16'd1);
    vecs[5]  = mk(0, 0, 0, 2'b11, 0, 0, 1, 0, 32'h1234,      0, 1, 32'h0,        32'h0,        32'h0,        16'd1);
    vecs[6]  = mk(0, 0, 5, 2'b11, 0, 0, 0, 0, 32'h0,         0, 1, 32'h0,        32'hDEADBEEF, 32'h0,        16'd1);
    vecs[7]  = mk(1, 0, 0, 2'b00, 7, 1, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,        32'h0,        16'd1);
    vecs[8]  = mk(1, 0, 0, 2'b00, 7, 1, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        32'h80,       16'd1);
    vecs[9]  = mk(1, 7, 0, 2'b01, 7, 1, 1, 7, 32'h77770007,  0, 1, 32'h77770007, 32'h0,        32'h80,       16'd2);
    vecs[10] = mk(0, 7, 5, 2'b00, 0, 0, 0, 0, 32'h0,         0, 1, 32'h77770007, 32'hDEADBEEF, 32'h80,       16'd2);
    vecs[11] = mk(1, 0, 0, 2'b00, 3, 1, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,        32'h80,       16'd2);
    vecs[12] = mk(1, 0, 0, 2'b00, 9, 1, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,        32'h88,       16'd2);
    vecs[13] = mk(1, 0, 0, 2'b00, 1, 1, 0, 0, 32'h0,         1, 0, 32'h0,        32'h0,        32'h288,      16'd2);
    vecs[14] = mk(0, 3, 0, 2'b01, 0, 0, 1, 3, 32'hA5,        0, 1, 32'hA5,       32'h0,        32'h0,        16'd3);
    vecs[15] = mk(0, 3, 9, 2'b11, 0, 0, 0, 0, 32'h0,         0, 1, 32'hA5,       32'h0,        32'h0,        16'd3);
    vecs[16] = mk(1, 0, 0, 2'b00, 4, 1, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,        32'h0,        16'd3);
    vecs[17] = mk(1, 0, 4, 2'b10, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        32'h10,       16'd3);
    vecs[18] = mk(1, 0, 4, 2'b01, 0, 0, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,        32'h10,       16'd4);
    vecs[19] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0,         0, 1, 32'h0,        32'h0,        32'h10,       16'd4);

    rst = 1'b0;
    idle_main();
    idle_b();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_busy", 64'(busy_vec), 64'h0);
    chk("reset_cnt", 64'(stall_cnt), 64'h0);
    chk("reset_ready", 64'(iss_ready), 64'h1);
    chk("reset_b_ready", 64'(b_iss_ready), 64'h1);

    // Table: drive just after an edge, check comb outputs and prior-edge state
    for (int i = 0; i < NV; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      iss_valid = vecs[i].iss_valid;
      rs_addr   = {vecs[i].rs1, vecs[i].rs0};
      rs_used   = vecs[i].used;
      rd_addr   = vecs[i].rd;
      rd_wen    = vecs[i].wen;
      wb_valid  = vecs[i].wbv;
      wb_addr   = vecs[i].wba;
      wb_data   = vecs[i].wbd;
      flush     = vecs[i].flush;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(iss_ready), 64'(vecs[i].e_ready));
      chk($sformatf("v%0d_rs0", i), 64'(rs_data[31:0]), 64'(vecs[i].e_rs0));
      chk($sformatf("v%0d_rs1", i), 64'(rs_data[63:32]), 64'(vecs[i].e_rs1));
      chk($sformatf("v%0d_busy", i), 64'(busy_vec), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d_cnt", i), 64'(stall_cnt), 64'(vecs[i].e_cnt));
    end

    // Reset mid-operation: stalled consumer, issue and write-back all discarded
    @(posedge clk);
    #1;
    rst = 1'b0;
    iss_valid = 1'b1; rs_addr = {5'd4, 5'd0}; rs_used = 2'b10;
    rd_addr = 5'd12; rd_wen = 1'b1;
    wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h66; flush = 1'b0;
    #1;
    chk("midrst_pre_ready", 64'(iss_ready), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_main();
    rs_addr = {5'd6, 5'd5}; rs_used = 2'b11;
    #1;
    chk("midrst_busy", 64'(busy_vec), 64'h0);
    chk("midrst_cnt", 64'(stall_cnt), 64'h0);
    chk("midrst_rf5", 64'(rs_data[31:0]), 64'h0);
    chk("midrst_rf6", 64'(rs_data[63:32]), 64'h0);
    chk("midrst_ready", 64'(iss_ready), 64'h1);

    // Three-lane instance: lane masking and counter saturation
    @(posedge clk);
    #1;
    b_iss_valid = 1'b1; b_rd_addr = 5'd6; b_rd_wen = 1'b1;
    #1;
    chk("b_issue_ready", 64'(b_iss_ready), 64'h1);
    @(posedge clk);
    #1;
    b_rd_wen = 1'b0; b_rd_addr = '0;
    b_rs_addr = {5'd6, 5'd0, 5'd0}; b_rs_used = 3'b100;
    #1;
    chk("b_lane2_stall", 64'(b_iss_ready), 64'h0);
    chk("b_busy6", 64'(b_busy_vec), 64'h40);
    chk("b_cnt0", 64'(b_stall_cnt), 64'h0);
    @(posedge clk);
    #1;
    b_rs_used = 3'b011;
    #1;
    chk("b_lane2_unused", 64'(b_iss_ready), 64'h1);
    chk("b_cnt1", 64'(b_stall_cnt), 64'h1);
    @(posedge clk);
    #1;
    b_rs_used = 3'b100;
    e_bcnt = 2'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("b_hold%0d_ready", k), 64'(b_iss_ready), 64'h0);
      @(posedge clk);
      #1;
      if (e_bcnt != 2'd3) e_bcnt = e_bcnt + 2'd1;
      chk($sformatf("b_hold%0d_cnt", k), 64'(b_stall_cnt), 64'(e_bcnt));
    end
    chk("b_cnt_saturated", 64'(b_stall_cnt), 64'h3);

    // Bypass on lane 2 releases the stall and clears the reservation
    b_wb_valid = 1'b1; b_wb_addr = 5'd6; b_wb_data = 32'hCAFE0006;
    #1;
    chk("b_byp_ready", 64'(b_iss_ready), 64'h1);
    chk("b_byp_lane2", 64'(b_rs_data[95:64]), 64'hCAFE0006);
    chk("b_lane0_x0", 64'(b_rs_data[31:0]), 64'h0);
    @(posedge clk);
    #1;
    idle_b();
    b_rs_addr = {5'd0, 5'd6, 5'd0};
    #1;
    chk("b_busy_cleared", 64'(b_busy_vec), 64'h0);
    chk("b_rf6_lane1", 64'(b_rs_data[63:32]), 64'hCAFE0006);
    chk("b_cnt_held", 64'(b_stall_cnt), 64'h3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
